// File: rtl/ram8x4_pkg.sv
// Shared sizing constants and FSM state encoding for the 8x4 writable memory.
package ram8x4_pkg;

  localparam int ADDR_W    = 3;
  localparam int DATA_W    = 4;
  localparam int DEPTH     = 2 ** ADDR_W;
  localparam int FILL_STEP = 2;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  // Default-image word for a given index, wrapped to the word width.
  function automatic logic [DATA_W-1:0] fill_word(input logic [ADDR_W-1:0] idx);
    return DATA_W'(int'(idx) * FILL_STEP);
  endfunction

endpackage

// File: rtl/ram8x4_core.sv
// Register array: one synchronous write port, one asynchronous read port.
module ram8x4_core
  import ram8x4_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset; its contents are defined by the fill FSM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Combinational read returns old data during a same-address write.
  assign rdata = mem[raddr];

endmodule

// File: rtl/ram8x4_writer.sv
// Write-side controller for the 8x4 memory: reset-time fill of the default
// image, then single or auto-increment writes over a valid/ready handshake.
module ram8x4_writer
  import ram8x4_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic              wr_burst,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_done,
  input  logic              fill_start,
  output logic              fill_busy,
  output logic [ADDR_W-1:0] ptr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fill_idx;
  logic              fill_last;
  logic              accept;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign fill_last = (fill_idx == ADDR_W'(DEPTH - 1));

  // A pending fill_start blocks writes so a re-fill always wins.
  assign wr_ready  = (state_q == IDLE) && !fill_start && !rst;
  assign fill_busy = (state_q == FILL) || rst;
  assign accept    = wr_valid && wr_ready;

  // NOTE: every output of this block gets a default first, so no latches.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL:    if (fill_last) state_d = IDLE;
      IDLE:    if (fill_start) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_burst ? ptr : wr_addr;
    mem_wdata = wr_data;
    if (!rst) begin
      if (state_q == FILL) begin
        mem_we    = 1'b1;
        mem_waddr = fill_idx;
        mem_wdata = fill_word(fill_idx);
      end else if (accept) begin
        mem_we = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FILL;
      fill_idx <= '0;
      ptr      <= '0;
      wr_done  <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_done <= accept;
      if (state_q == FILL) begin
        fill_idx <= fill_idx + ADDR_W'(1);
        if (fill_last) ptr <= '0;
      end else if (fill_start) begin
        fill_idx <= '0;
      end
      if (accept && wr_burst) ptr <= ptr + ADDR_W'(1);
    end
  end

  ram8x4_core u_core (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_ram8x4_writer.sv
// Directed bench for ram8x4_writer: reset fill, single and burst writes,
// fill-vs-write priority, reset mid-fill and read-during-write.
module tb_ram8x4_writer;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid;
  logic       wr_ready;
  logic       wr_burst;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic       wr_done;
  logic       fill_start;
  logic       fill_busy;
  logic [2:0] ptr;
  logic [2:0] rd_addr;
  logic [3:0] rd_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram8x4_writer dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_burst   (wr_burst),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_done    (wr_done),
    .fill_start (fill_start),
    .fill_busy  (fill_busy),
    .ptr        (ptr),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_check(input string tag, input logic [2:0] a, input logic [3:0] exp);
    rd_addr = a;
    #1;
    check(tag, 32'(rd_data), 32'(exp));
  endtask

  logic [3:0] img [8];
  logic [3:0] burst_img [8];

  initial begin
    for (int i = 0; i < 8; i++) img[i] = 4'(i * 2);
    burst_img[0] = 4'h9;
    for (int i = 1; i < 8; i++) burst_img[i] = 4'(i + 1);

    rst = 1'b1; wr_valid = 1'b0; wr_burst = 1'b0; wr_addr = '0;
    wr_data = '0; fill_start = 1'b0; rd_addr = '0;

    // 1. reset for two cycles, then the default fill
    tick(); tick();
    check("rst_fill_busy", 32'(fill_busy), 32'd1);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    check("rst_ptr", 32'(ptr), 32'd0);
    check("rst_wr_done", 32'(wr_done), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("fill_busy_c%0d", i), 32'(fill_busy), 32'd1);
      tick();
    end
    check("fill_done", 32'(fill_busy), 32'd0);
    check("idle_wr_ready", 32'(wr_ready), 32'd1);
    for (int i = 0; i < 8; i++) read_check($sformatf("img_%0d", i), 3'(i), img[i]);
    check("img_ptr", 32'(ptr), 32'd0);

    // 2. single write of F to address 5
    wr_burst = 1'b0; wr_addr = 3'd5; wr_data = 4'hF; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    check("single_done", 32'(wr_done), 32'd1);
    read_check("single_a5", 3'd5, 4'hF);
    read_check("single_a4", 3'd4, 4'h8);
    check("single_ptr", 32'(ptr), 32'd0);
    tick();
    check("single_done_clr", 32'(wr_done), 32'd0);

    // 3. nine back-to-back burst writes of 1..9, wrapping the pointer
    wr_burst = 1'b1;
    for (int d = 1; d <= 9; d++) begin
      wr_data = 4'(d); wr_valid = 1'b1;
      tick();
      check($sformatf("burst_done_%0d", d), 32'(wr_done), 32'd1);
    end
    wr_valid = 1'b0;
    check("burst_ptr", 32'(ptr), 32'd1);
    for (int i = 0; i < 8; i++) read_check($sformatf("burst_%0d", i), 3'(i), burst_img[i]);
    tick();
    check("burst_done_clr", 32'(wr_done), 32'd0);

    // 4. fill_start and a write in the same cycle: fill wins
    wr_burst = 1'b0; wr_addr = 3'd3; wr_data = 4'h0; wr_valid = 1'b1; fill_start = 1'b1;
    #1;
    check("prio_wr_ready", 32'(wr_ready), 32'd0);
    tick();
    wr_valid = 1'b0; fill_start = 1'b0;
    check("prio_wr_done", 32'(wr_done), 32'd0);
    check("prio_busy", 32'(fill_busy), 32'd1);
    read_check("prio_a3_old", 3'd3, 4'h4);
    for (int i = 0; i < 8; i++) tick();
    check("prio_fill_done", 32'(fill_busy), 32'd0);
    read_check("prio_a3_fill", 3'd3, 4'h6);
    check("prio_ptr", 32'(ptr), 32'd0);

    // 5. memory all F (ptr left at 1), re-fill, reset at fill cycle 4
    wr_burst = 1'b1; wr_data = 4'hF;
    for (int i = 0; i < 9; i++) begin
      wr_valid = 1'b1;
      tick();
    end
    wr_valid = 1'b0;
    check("allf_ptr", 32'(ptr), 32'd1);
    read_check("allf_a6", 3'd6, 4'hF);
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    read_check("midfill_a3", 3'd3, 4'h6);
    read_check("midfill_a4", 3'd4, 4'hF);
    rst = 1'b1;
    tick();
    check("midrst_ptr", 32'(ptr), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("refill_busy_c%0d", i), 32'(fill_busy), 32'd1);
      tick();
    end
    check("refill_done", 32'(fill_busy), 32'd0);
    for (int i = 0; i < 8; i++) read_check($sformatf("refill_%0d", i), 3'(i), img[i]);

    // 6. read-during-write to the same address
    rd_addr = 3'd2; wr_burst = 1'b0; wr_addr = 3'd2; wr_data = 4'hA; wr_valid = 1'b1;
    #1;
    check("rdw_old", 32'(rd_data), 32'h4);
    tick();
    wr_valid = 1'b0;
    #1;
    check("rdw_new", 32'(rd_data), 32'hA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
